// File: rtl/mem_stage_pkg.sv
// Shared types and width helpers for the lapido MEM stage.
// State encodings match the core-wide MEM_IDLE / MEM_ACCESS values.
package mem_stage_pkg;

  localparam int DEF_PC_WIDTH = 32;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_e;

  // Fields carried unchanged from EX/MEM to MEM/WB (excluding alu_res and mem_data)
  function automatic int pass_width(input int pc_w);
    return 4 + 2 + pc_w + 64 + 5;
  endfunction

  // Full MEM/WB word: valid + pass fields + alu_res + mem_data
  function automatic int wb_width(input int pc_w);
    return 1 + pass_width(pc_w) + 64;
  endfunction

endpackage

// File: rtl/mem_stage_wb_reg.sv
// Generic pipeline register with async reset; a bubble loads all zeros.
// Reused at other stage boundaries, so it knows nothing about field layout.
module mem_wb_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         q <= '0;
    else if (bubble) q <= '0;
    else             q <= d;
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data-memory req/ack handshake, upstream stall, and
// the MEM/WB pipeline register feeding the writeback stage.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_WIDTH = DEF_PC_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_mem_read,
  input  logic                in_mem_write,
  input  logic [31:0]         in_alu_res,
  input  logic [31:0]         in_store_data,
  input  logic                in_is_jump,
  input  logic                in_branch_taken,
  input  logic                in_branch_addr,
  input  logic                in_reg_write_enable,
  input  logic [1:0]          in_wb_res_mux,
  input  logic [PC_WIDTH-1:0] in_next_pc,
  input  logic [31:0]         in_imm,
  input  logic [31:0]         in_jump_addr,
  input  logic [4:0]          in_reg_dst,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_ack,
  input  logic [31:0]         dmem_rdata,
  output logic                stall,
  output logic                out_valid,
  output logic                out_is_jump,
  output logic                out_branch_taken,
  output logic                out_branch_addr,
  output logic                out_reg_write_enable,
  output logic [1:0]          out_wb_res_mux,
  output logic [PC_WIDTH-1:0] out_next_pc,
  output logic [31:0]         out_mem_data,
  output logic [31:0]         out_alu_res,
  output logic [31:0]         out_imm,
  output logic [31:0]         out_jump_addr,
  output logic [4:0]          out_reg_dst
);

  localparam int PASS_W = pass_width(PC_WIDTH);
  localparam int WB_W   = wb_width(PC_WIDTH);

  mem_state_e        state, state_nxt;
  logic              mem_op;
  logic              in_access;
  logic [PASS_W-1:0] in_pass;
  logic [PASS_W-1:0] h_pass;
  logic              h_we;
  logic [31:0]       h_alu_res;
  logic [31:0]       h_wdata;
  logic [WB_W-1:0]   wb_d;
  logic [WB_W-1:0]   wb_q;
  logic              wb_bubble;

  assign mem_op    = in_valid & (in_mem_read | in_mem_write);
  assign in_access = (state == MEM_ACCESS);
  assign in_pass   = {in_is_jump, in_branch_taken, in_branch_addr, in_reg_write_enable,
                      in_wb_res_mux, in_next_pc, in_imm, in_jump_addr, in_reg_dst};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE:   if (mem_op) state_nxt = MEM_ACCESS;
      MEM_ACCESS: if (dmem_ack) state_nxt = MEM_IDLE;
      default:    state_nxt = MEM_IDLE;
    endcase
  end

  // Read wins when both read and write are requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_pass    <= '0;
      h_we      <= 1'b0;
      h_alu_res <= '0;
      h_wdata   <= '0;
    end else if (state == MEM_IDLE && mem_op) begin
      h_pass    <= in_pass;
      h_we      <= in_mem_write & ~in_mem_read;
      h_alu_res <= in_alu_res;
      h_wdata   <= in_store_data;
    end
  end

  assign dmem_req   = in_access;
  assign dmem_we    = in_access & h_we;
  assign dmem_addr  = in_access ? h_alu_res : 32'd0;
  assign dmem_wdata = in_access ? h_wdata : 32'd0;

  assign stall = ~rst & (((state == MEM_IDLE) & mem_op) | (in_access & ~dmem_ack));

  always_comb begin
    wb_d      = '0;
    wb_bubble = 1'b1;
    case (state)
      MEM_IDLE: begin
        if (in_valid && !mem_op) begin
          wb_bubble = 1'b0;
          wb_d      = {1'b1, in_pass, in_alu_res, 32'd0};
        end
      end
      MEM_ACCESS: begin
        if (dmem_ack) begin
          wb_bubble = 1'b0;
          wb_d      = {1'b1, h_pass, h_alu_res, (h_we ? 32'd0 : dmem_rdata)};
        end
      end
      default: ;
    endcase
  end

  mem_wb_reg #(.WIDTH(WB_W)) u_mem_wb (
    .clk    (clk),
    .rst    (rst),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign {out_valid, out_is_jump, out_branch_taken, out_branch_addr, out_reg_write_enable,
          out_wb_res_mux, out_next_pc, out_imm, out_jump_addr, out_reg_dst,
          out_alu_res, out_mem_data} = wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instructions, each compared against expected writeback values.
module tb_mem_stage;

  localparam int PCW = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid, in_mem_read, in_mem_write;
  logic [31:0]    in_alu_res, in_store_data;
  logic           in_is_jump, in_branch_taken, in_branch_addr, in_reg_write_enable;
  logic [1:0]     in_wb_res_mux;
  logic [PCW-1:0] in_next_pc;
  logic [31:0]    in_imm, in_jump_addr;
  logic [4:0]     in_reg_dst;
  logic           dmem_req, dmem_we, dmem_ack;
  logic [31:0]    dmem_addr, dmem_wdata, dmem_rdata;
  logic           stall, out_valid, out_is_jump, out_branch_taken, out_branch_addr;
  logic           out_reg_write_enable;
  logic [1:0]     out_wb_res_mux;
  logic [PCW-1:0] out_next_pc;
  logic [31:0]    out_mem_data, out_alu_res, out_imm, out_jump_addr;
  logic [4:0]     out_reg_dst;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        vld, rd, wr, jmp, bt, ba, rwe;
    logic [1:0]  mux;
    logic [31:0] npc, alu, sd, imm, ja;
    logic [4:0]  dst;
  } ins_t;

  mem_stage #(.PC_WIDTH(PCW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_alu_res(in_alu_res), .in_store_data(in_store_data),
    .in_is_jump(in_is_jump), .in_branch_taken(in_branch_taken),
    .in_branch_addr(in_branch_addr), .in_reg_write_enable(in_reg_write_enable),
    .in_wb_res_mux(in_wb_res_mux), .in_next_pc(in_next_pc),
    .in_imm(in_imm), .in_jump_addr(in_jump_addr), .in_reg_dst(in_reg_dst),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .out_valid(out_valid), .out_is_jump(out_is_jump),
    .out_branch_taken(out_branch_taken), .out_branch_addr(out_branch_addr),
    .out_reg_write_enable(out_reg_write_enable), .out_wb_res_mux(out_wb_res_mux),
    .out_next_pc(out_next_pc), .out_mem_data(out_mem_data), .out_alu_res(out_alu_res),
    .out_imm(out_imm), .out_jump_addr(out_jump_addr), .out_reg_dst(out_reg_dst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input ins_t i);
    in_valid = i.vld; in_mem_read = i.rd; in_mem_write = i.wr;
    in_alu_res = i.alu; in_store_data = i.sd;
    in_is_jump = i.jmp; in_branch_taken = i.bt; in_branch_addr = i.ba;
    in_reg_write_enable = i.rwe; in_wb_res_mux = i.mux; in_next_pc = i.npc;
    in_imm = i.imm; in_jump_addr = i.ja; in_reg_dst = i.dst;
  endtask

  function automatic ins_t blank();
    ins_t i;
    i.vld = 0; i.rd = 0; i.wr = 0; i.jmp = 0; i.bt = 0; i.ba = 0; i.rwe = 0;
    i.mux = 0; i.npc = 0; i.alu = 0; i.sd = 0; i.imm = 0; i.ja = 0; i.dst = 0;
    return i;
  endfunction

  // kind: 0 alu, 1 load, 2 store, 3 read+write (illegal), 4 invalid slot
  function automatic ins_t rand_ins(input int kind);
    ins_t i;
    i.vld = (kind != 4);
    i.rd  = (kind == 1 || kind == 3 || (kind == 4 && $urandom_range(0, 1) == 1));
    i.wr  = (kind == 2 || kind == 3);
    i.jmp = 1'($urandom); i.bt = 1'($urandom); i.ba = 1'($urandom);
    i.rwe = 1'($urandom); i.mux = 2'($urandom);
    i.npc = $urandom; i.alu = $urandom; i.sd = $urandom;
    i.imm = $urandom; i.ja = $urandom; i.dst = 5'($urandom);
    return i;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after writeback.
  task automatic run_ins(input ins_t i, input int waits, input logic [31:0] rdata, input string tag);
    logic        mem;
    logic [31:0] exp_md;
    mem = i.vld && (i.rd || i.wr);
    drive(i);
    #1;
    chk({tag, ".stall_first"}, stall, mem);
    chk({tag, ".req_idle"}, dmem_req, 1'b0);
    exp_md = 32'd0;
    if (mem) begin
      @(posedge clk); @(negedge clk);
      for (int k = 0; k <= waits; k++) begin
        dmem_ack   = (k == waits);
        dmem_rdata = (k == waits) ? rdata : $urandom;
        #1;
        chk({tag, ".req"}, dmem_req, 1'b1);
        chk({tag, ".we"}, dmem_we, i.wr & ~i.rd);
        chk({tag, ".addr"}, dmem_addr, i.alu);
        chk({tag, ".wdata"}, dmem_wdata, i.sd);
        chk({tag, ".stall_wait"}, stall, (k < waits));
        chk({tag, ".bubble"}, out_valid, 1'b0);
        @(posedge clk); @(negedge clk);
      end
      dmem_ack = 1'b0;
      if (i.rd) exp_md = rdata;
    end else begin
      @(posedge clk); @(negedge clk);
    end
    chk({tag, ".out_valid"}, out_valid, i.vld);
    if (i.vld) begin
      chk({tag, ".is_jump"}, out_is_jump, i.jmp);
      chk({tag, ".br_taken"}, out_branch_taken, i.bt);
      chk({tag, ".br_addr"}, out_branch_addr, i.ba);
      chk({tag, ".rwe"}, out_reg_write_enable, i.rwe);
      chk({tag, ".mux"}, out_wb_res_mux, i.mux);
      chk({tag, ".next_pc"}, out_next_pc, i.npc);
      chk({tag, ".mem_data"}, out_mem_data, exp_md);
      chk({tag, ".alu_res"}, out_alu_res, i.alu);
      chk({tag, ".imm"}, out_imm, i.imm);
      chk({tag, ".jump_addr"}, out_jump_addr, i.ja);
      chk({tag, ".reg_dst"}, out_reg_dst, i.dst);
    end else begin
      chk({tag, ".inv_ctrl"}, {out_is_jump, out_branch_taken, out_branch_addr, out_reg_write_enable},
          4'd0);
    end
  endtask

  initial begin
    ins_t i;
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    drive(blank());
    @(negedge clk); @(negedge clk);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.req", dmem_req, 1'b0);
    chk("rst.we", dmem_we, 1'b0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.stall", stall, 1'b0);
    chk("rst.mem_data", out_mem_data, 32'd0);
    chk("rst.reg_dst", out_reg_dst, 5'd0);
    rst = 1'b0;
    @(negedge clk);

    i = blank(); i.vld = 1; i.alu = 32'h10; i.dst = 5'd5; i.rwe = 1; i.mux = 2'd0;
    run_ins(i, 0, 32'h0, "alu");

    i = blank(); i.vld = 1; i.rd = 1; i.alu = 32'h40; i.dst = 5'd7; i.rwe = 1; i.mux = 2'd1;
    run_ins(i, 0, 32'hDEADBEEF, "load0");

    i = blank(); i.vld = 1; i.wr = 1; i.alu = 32'h44; i.sd = 32'h12345678; i.dst = 5'd0;
    run_ins(i, 3, 32'hCAFEF00D, "store3");

    i = blank(); i.vld = 1; i.rd = 1; i.alu = 32'h80; i.dst = 5'd1; i.rwe = 1; i.mux = 2'd1;
    run_ins(i, 0, 32'hA5A50001, "b2b_a");
    i.alu = 32'h84; i.dst = 5'd2;
    run_ins(i, 0, 32'h5A5A0002, "b2b_b");

    i = blank(); i.vld = 1; i.jmp = 1; i.npc = 32'h2A; i.ja = 32'h100; i.dst = 5'd31;
    i.rwe = 1; i.mux = 2'd2;
    run_ins(i, 0, 32'h0, "jal");

    i = blank(); i.vld = 1; i.rd = 1; i.wr = 1; i.alu = 32'h60; i.sd = 32'h77; i.dst = 5'd9;
    run_ins(i, 1, 32'h0BADCAFE, "rdwr");

    for (int n = 0; n < 40; n++) begin
      i = rand_ins($urandom_range(0, 4));
      run_ins(i, $urandom_range(0, 3), $urandom, "rand");
    end

    // Reset while an access is outstanding, then a stray ack afterwards
    i = blank(); i.vld = 1; i.rd = 1; i.alu = 32'h200; i.dst = 5'd3; i.rwe = 1;
    drive(i);
    @(posedge clk); @(negedge clk);
    #1;
    chk("rstacc.req_before", dmem_req, 1'b1);
    rst = 1'b1;
    drive(blank());
    #1;
    chk("rstacc.req", dmem_req, 1'b0);
    chk("rstacc.out_valid", out_valid, 1'b0);
    chk("rstacc.stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF0000;
    #1;
    chk("rstacc.late_stall", stall, 1'b0);
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    chk("rstacc.late_valid", out_valid, 1'b0);
    chk("rstacc.late_req", dmem_req, 1'b0);
    chk("rstacc.late_rwe", out_reg_write_enable, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the core_lapido pipeline, directly upstream of WB_stage. It takes the EX/MEM fields and performs the data-memory load or store through a req/ack handshake, stalling the pipeline while an access is outstanding. It also registers the MEM/WB pipeline fields that WB_stage consumes.

## Interface
- PC_WIDTH, default `PC_WIDTH` (lapido_defs.v): width of the PC-valued fields.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM slot holds a real instruction.
- in_mem_read / in_mem_write  in  1 each  load / store request.
- in_alu_res  in  32  ALU result; also the memory address.
- in_store_data  in  32  store data.
- in_is_jump, in_branch_taken, in_branch_addr, in_reg_write_enable  in  1 each  control fields passed through.
- in_wb_res_mux  in  2  WB select; passed through.
- in_next_pc  in  PC_WIDTH  PC+1 value for jal.
- in_imm, in_jump_addr  in  32 each  passed through.
- in_reg_dst  in  5  destination register.
- dmem_req  out  1  memory request strobe.
- dmem_we  out  1  1 = write.
- dmem_addr, dmem_wdata  out  32 each  address and write data.
- dmem_ack  in  1  access complete; rdata is valid in the same cycle for a load.
- dmem_rdata  in  32  load data.
- stall  out  1  freeze all stages upstream of MEM.
- out_valid  out  1  MEM/WB slot holds a real instruction.
- out_is_jump, out_branch_taken, out_branch_addr, out_reg_write_enable  out  1 each  registered, gated by out_valid.
- out_wb_res_mux  out  2.
- out_next_pc  out  PC_WIDTH.
- out_mem_data, out_alu_res, out_imm, out_jump_addr  out  32 each.
- out_reg_dst  out  5.

## Operation
- The FSM has three states.
  - IDLE: no access outstanding.
  - ACCESS: dmem_req is high, waiting for ack.
  - A third state, DONE, is not used: a completed access returns to IDLE in the same edge.
- In IDLE, an instruction with in_valid=1 and (in_mem_read or in_mem_write) moves the FSM to ACCESS. Its fields are latched into an internal hold register.
- In ACCESS, dmem_req=1, and dmem_we/addr/wdata are driven from the hold register, stable until ack.
  - When dmem_ack=1: return to IDLE, and the MEM/WB register loads the held fields with out_mem_data=dmem_rdata (stores: out_mem_data=0) and out_valid=1.
  - While dmem_ack=0: the MEM/WB register loads a bubble (out_valid=0, all out_* control bits 0).
- A non-memory instruction (or in_valid=0) in IDLE goes straight to MEM/WB on the next edge with out_mem_data=0. It causes no stall.
- stall is combinational: stall = (state==IDLE & in_valid & (rd|wr)) | (state==ACCESS & ~dmem_ack). Upstream holds EX/MEM while stall=1.
- in_mem_read and in_mem_write both high is illegal. It is treated as a read, with dmem_we=0.
- dmem_ack while in IDLE is ignored.
- rst clears:
  - state to IDLE;
  - dmem_req, dmem_we and stall to 0;
  - dmem_addr and dmem_wdata to 0;
  - every out_* to 0, including out_valid.
- Reset during ACCESS abandons the access. A late ack after reset is ignored.

## Timing
- Non-memory instruction: 1 cycle latency EX/MEM to MEM/WB, no stall.
- Memory instruction:
  - Edge N: latch into the hold register; dmem_req rises after edge N.
  - First possible ack is in cycle N+1; MEM/WB is valid after that edge.
  - Minimum latency is 2 cycles; stall=1 for 1 + (wait cycles) cycles.
- Back-to-back memory instructions: the second is accepted in the IDLE cycle immediately after the ack edge. dmem_req drops for one cycle between accesses.
- No combinational path from dmem_rdata to any output other than through the MEM/WB register.

## Structure
- lapido_defs.v holds `PC_WIDTH` and the state encodings `MEM_IDLE`=2'd0 and `MEM_ACCESS`=2'd1.
- One sub-module, mem_wb_reg: a parameterised pipeline register with async reset and a bubble input. It is reused later for other stage boundaries.
- The FSM and handshake live in mem_stage.

## Test plan
- Reset mid-ACCESS:
  - Stimulus: rst asserted during ACCESS, then ack=1 one cycle after release.
  - Required: dmem_req=0 and out_valid=0 immediately; the late ack causes no writeback.
- ALU instruction:
  - Stimulus: alu_res=0x00000010, reg_dst=5, wb_res_mux=0.
  - Required: out_* valid one cycle later, stall never high, out_mem_data=0.
- Load with zero wait:
  - Stimulus: addr 0x40, ack in the first ACCESS cycle, rdata=0xDEADBEEF.
  - Required: stall high for 1 cycle; out_mem_data=0xDEADBEEF, out_reg_dst correct, 2-cycle latency.
- Store with 3 wait cycles:
  - Stimulus: addr 0x44, wdata=0x12345678.
  - Required: req/we/addr/wdata stable for 4 cycles; stall high for 4 cycles; 3 bubbles then out_valid=1 with out_reg_write_enable=0.
- Back-to-back loads:
  - Stimulus: loads to 0x80 and 0x84, each acked immediately.
  - Required: two writebacks with correct data in order; one req-low cycle between them.
- jal through MEM:
  - Stimulus: in_is_jump=1, next_pc=0x2A, jump_addr=0x100.
  - Required: fields arrive unchanged at out_* one cycle later with no memory request.
